aes_128_encrypt_core: RTL and testbench
=======================================

AES_128_ENCRYPT_CORE -- requirements
Module: aes_128_encrypt_core

Interface
REQ-001 The module SHALL have no parameters; the key size (128) and round count (10) SHALL be fixed.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to encrypt; sampled only in IDLE.
REQ-005 INPUT_DATA  input  128  plaintext; byte 0 = bits [127:120], column-major per FIPS-197.
REQ-006 INPUT_KEY  input  128  cipher key, same byte order as INPUT_DATA.
REQ-007 busy  output  1  high while rounds are in progress.
REQ-008 done  output  1  one-cycle pulse when OUTPUT_DATA is updated.
REQ-009 OUTPUT_DATA  output  128  ciphertext, registered, same byte order.

Function
REQ-010 The FSM SHALL have two states: IDLE and ROUND. A round counter rnd SHALL be 4 bits, range 1..10.
REQ-011 In IDLE with start=1 at edge t0, the core SHALL:
- load state = INPUT_DATA ^ INPUT_KEY;
- load ROUND_KEYS[0] = INPUT_KEY;
- set rnd = 1;
- enter ROUND and set busy = 1.
REQ-012 In ROUND, each edge SHALL apply the following to state:
- SubBytes, ShiftRows, MixColumns (MixColumns omitted when rnd = 10);
- AddRoundKey with key rnd.
REQ-013 Key rnd SHALL be expanded on the fly, combinationally, from ROUND_KEYS[rnd-1] using RotWord, SubWord and Rcon[rnd] (01,02,04,08,10,20,40,80,1b,36). It SHALL be stored into ROUND_KEYS[rnd] on the same edge.
REQ-014 ROUND_KEYS[0..10] SHALL be an internal 11x128 register array holding every key of the last operation. The array SHALL be readable hierarchically and SHALL hold its contents until the next start.
REQ-015 At edge t10 (rnd = 10), the core SHALL:
- load OUTPUT_DATA with the final state;
- set done = 1 for exactly one cycle;
- clear busy;
- return to IDLE.
REQ-016 Latency: done SHALL be high in the cycle following edge t10, i.e. 10 clocks after the start-sampling edge. Throughput SHALL be one block per 11 cycles.
REQ-017 start while busy = 1 SHALL be ignored. INPUT_DATA and INPUT_KEY changes after t0 SHALL NOT affect the result in progress.
REQ-018 start = 1 in the cycle where done = 1 (FSM in IDLE) SHALL be accepted immediately, giving back-to-back operation.
REQ-019 OUTPUT_DATA SHALL hold the last ciphertext until the next completion and SHALL never show intermediate round state.
REQ-020 busy and done SHALL never be high simultaneously.

Reset
REQ-021 reset = 1 SHALL force the following on the next edge, with priority over start:
- FSM to IDLE, rnd = 0;
- busy = 0, done = 0, OUTPUT_DATA = 0;
- state = 0, all ROUND_KEYS = 0.
REQ-022 reset asserted mid-operation SHALL abort the operation with no done pulse. The first start after reset deasserts SHALL be accepted normally.

Structure
REQ-023 Package aes_pkg SHALL hold:
- the S-box table/function;
- the Rcon table;
- xtime;
- the constants NR = 10 and BLOCK_W = 128.
The decrypt core SHALL share this package.
REQ-024 Sub-module aes_sbox (8-bit combinational lookup) SHALL be instantiated 20 times: 16 for the state bytes and 4 for key SubWord.
REQ-025 ShiftRows, MixColumns and key expansion SHALL be combinational logic inside aes_128_encrypt_core, with one register stage per round.

Verification
REQ-026 FIPS-197 C.1 vector:
- Stimulus: INPUT_KEY = 000102030405060708090a0b0c0d0e0f, INPUT_DATA = 00112233445566778899aabbccddeeff, start pulse.
- Response: OUTPUT_DATA = 69c4e0d86a7b0430d8cdb78070b4c55a with done exactly 10 clocks after the start edge.
REQ-027 FIPS-197 Appendix B vector:
- Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734.
- Response: OUTPUT_DATA = 3925841d02dc09fbdc118597196a0b32 and ROUND_KEYS[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-028 Busy-start and input-change test:
- Stimulus: all-zero key and data; start held high for 15 cycles; INPUT_DATA changed at cycle 3.
- Response: exactly one done in the first 11 cycles with OUTPUT_DATA = 66e94bd4ef8a2c3b884cfa59ca342b2e; a second operation accepted in the done cycle.
REQ-029 Reset mid-operation:
- Stimulus: reset asserted at rnd = 5.
- Response: busy = 0, done never pulses, OUTPUT_DATA = 0. A fresh start then reproduces the REQ-026 result.
REQ-030 Back-to-back operation:
- Stimulus: C.1 vector, then the Appendix B vector with start in the done cycle.
- Response: both ciphertexts correct; done pulses 11 cycles apart.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants and byte-level helpers for the encrypt and decrypt cores.
package aes_pkg;

    localparam int NR      = 10;
    localparam int BLOCK_W = 128;

    typedef enum logic {
        IDLE,
        ROUND
    } fsm_state_e;

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Entry 0 is unused so the table is indexed directly by round number.
    localparam logic [0:10][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX[a];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single AES S-box lookup, purely combinational.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = sbox(din);

endmodule

// File: rtl/aes_128_encrypt_core.sv
// Iterative AES-128 encryptor: one full round per clock, key schedule expanded on the fly.
module aes_128_encrypt_core
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [BLOCK_W-1:0] INPUT_DATA,
    input  logic [BLOCK_W-1:0] INPUT_KEY,
    output logic               busy,
    output logic               done,
    output logic [BLOCK_W-1:0] OUTPUT_DATA
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    fsm_state_e         fsm_q;
    logic [3:0]         rnd;
    logic [BLOCK_W-1:0] state_q;
    logic [BLOCK_W-1:0] ROUND_KEYS [0:NR];

    logic [7:0]         sb [16];
    logic [7:0]         sr [16];
    logic [7:0]         mc [16];
    logic [BLOCK_W-1:0] round_out;

    logic [BLOCK_W-1:0] prev_key;
    logic [BLOCK_W-1:0] next_key;
    logic [31:0]        rot_word;
    logic [31:0]        sub_word;
    logic [31:0]        temp_word;
    logic [31:0]        w0, w1, w2, w3;
    logic [7:0]         rcon_byte;

    // Byte i of the block sits at bits [127-8i -: 8]; i = row + 4*col.
    for (genvar i = 0; i < 16; i++) begin : g_state_sbox
        aes_sbox u_sbox (
            .din  (state_q[BLOCK_W-1-8*i -: 8]),
            .dout (sb[i])
        );
    end

    for (genvar j = 0; j < 4; j++) begin : g_key_sbox
        aes_sbox u_sbox (
            .din  (rot_word[31-8*j -: 8]),
            .dout (sub_word[31-8*j -: 8])
        );
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        prev_key  = '0;
        rcon_byte = 8'h00;
        if (rnd != 4'd0 && rnd <= LAST_RND) begin
            prev_key  = ROUND_KEYS[rnd - 4'd1];
            rcon_byte = RCON[rnd];
        end
        rot_word  = {prev_key[23:0], prev_key[31:24]};
        temp_word = sub_word ^ {rcon_byte, 24'h000000};
        w0        = prev_key[127:96] ^ temp_word;
        w1        = prev_key[95:64]  ^ w0;
        w2        = prev_key[63:32]  ^ w1;
        w3        = prev_key[31:0]   ^ w2;
        next_key  = {w0, w1, w2, w3};
    end

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            sr[k] = 8'h00;
            mc[k] = 8'h00;
        end
        // ShiftRows: row r rotates left by r columns.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        round_out = '0;
        for (int k = 0; k < 16; k++) begin
            round_out[BLOCK_W-1-8*k -: 8] = ((rnd == LAST_RND) ? sr[k] : mc[k])
                                            ^ next_key[BLOCK_W-1-8*k -: 8];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q       <= IDLE;
            rnd         <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            OUTPUT_DATA <= '0;
            state_q     <= '0;
            // NOTE: the key array is cleared on reset because it is observable from outside.
            for (int k = 0; k <= NR; k++) begin
                ROUND_KEYS[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start) begin
                        state_q       <= INPUT_DATA ^ INPUT_KEY;
                        ROUND_KEYS[0] <= INPUT_KEY;
                        rnd           <= 4'd1;
                        busy          <= 1'b1;
                        fsm_q         <= ROUND;
                    end
                end
                ROUND: begin
                    state_q         <= round_out;
                    ROUND_KEYS[rnd] <= next_key;
                    if (rnd == LAST_RND) begin
                        OUTPUT_DATA <= round_out;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        fsm_q       <= IDLE;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_128_encrypt_core.sv
// Directed bench for aes_128_encrypt_core using FIPS-197 reference vectors.
module tb_aes_128_encrypt_core;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] INPUT_DATA;
    logic [127:0] INPUT_KEY;
    logic         busy;
    logic         done;
    logic [127:0] OUTPUT_DATA;

    always #5 clk = ~clk;

    aes_128_encrypt_core dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .INPUT_DATA  (INPUT_DATA),
        .INPUT_KEY   (INPUT_KEY),
        .busy        (busy),
        .done        (done),
        .OUTPUT_DATA (OUTPUT_DATA)
    );

    typedef struct {
        logic [127:0] key;
        logic [127:0] data;
        logic [127:0] cipher;
        logic [127:0] rk1;
        logic [127:0] rk10;
    } vec_t;

    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] ZERO_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    vec_t vecs [3];
    int   n_pass  = 0;
    int   n_total = 0;
    logic overlap_seen = 1'b0;

    always @(negedge clk) begin
        if (busy && done) overlap_seen = 1'b1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Leaves the bench at the falling edge just after the start-sampling edge.
    task automatic start_op(input logic [127:0] key, input logic [127:0] data);
        @(negedge clk);
        INPUT_KEY  = key;
        INPUT_DATA = data;
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 30) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int lat2;
        int n_first;
        int n_second;
        int first_c;
        int second_c;
        int dones_in_reset;
        logic         busy11;
        logic [127:0] out_first;

        vecs[0] = '{key: C1_KEY, data: C1_PT, cipher: C1_CT,
                    rk1:  128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                    rk10: 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[1] = '{key: B_KEY, data: B_PT, cipher: B_CT,
                    rk1:  128'ha0fafe1788542cb123a339392a6c7605,
                    rk10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[2] = '{key: '0, data: '0, cipher: ZERO_CT,
                    rk1:  128'h62636363626363636263636362636363,
                    rk10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        reset      = 1'b1;
        start      = 1'b0;
        INPUT_DATA = '0;
        INPUT_KEY  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        check("reset_out", OUTPUT_DATA, '0);
        check("reset_rk10", dut.ROUND_KEYS[10], '0);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            start_op(vecs[i].key, vecs[i].data);
            check($sformatf("vec%0d_busy", i), 128'(busy), 128'd1);
            wait_done(lat);
            check($sformatf("vec%0d_latency", i), 128'(lat), 128'd10);
            check($sformatf("vec%0d_out", i), OUTPUT_DATA, vecs[i].cipher);
            check($sformatf("vec%0d_busy_at_done", i), 128'(busy), 128'd0);
            check($sformatf("vec%0d_rk1", i), dut.ROUND_KEYS[1], vecs[i].rk1);
            check($sformatf("vec%0d_rk10", i), dut.ROUND_KEYS[10], vecs[i].rk10);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 128'(done), 128'd0);
            check($sformatf("vec%0d_out_hold", i), OUTPUT_DATA, vecs[i].cipher);
        end

        // Start held high through busy; data changes mid-operation.
        n_first  = 0;
        n_second = 0;
        first_c  = -1;
        second_c = -1;
        busy11   = 1'b0;
        out_first = '0;
        @(negedge clk);
        INPUT_KEY  = '0;
        INPUT_DATA = '0;
        start      = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                if (c <= 10) begin
                    n_first++;
                    first_c   = c;
                    out_first = OUTPUT_DATA;
                end else begin
                    n_second++;
                    second_c = c;
                end
            end
            if (c == 11) busy11 = busy;
            if (c == 2) INPUT_DATA = {16{8'hff}};
            if (c == 14) start = 1'b0;
        end
        check("held_start_done_count", 128'(n_first), 128'd1);
        check("held_start_done_cycle", 128'(first_c), 128'd10);
        check("held_start_out", out_first, ZERO_CT);
        check("held_start_rearm_busy", 128'(busy11), 128'd1);
        check("held_start_second_count", 128'(n_second), 128'd1);
        check("held_start_second_cycle", 128'(second_c), 128'd21);

        // Reset in the middle of an operation.
        start_op(C1_KEY, C1_PT);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("abort_rnd", 128'(dut.rnd), 128'd5);
        reset = 1'b1;
        dones_in_reset = 0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones_in_reset++;
        end
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_out", OUTPUT_DATA, '0);
        check("abort_state", dut.state_q, '0);
        check("abort_rk0", dut.ROUND_KEYS[0], '0);
        reset = 1'b0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones_in_reset++;
        end
        check("abort_no_done", 128'(dones_in_reset), 128'd0);
        start_op(C1_KEY, C1_PT);
        wait_done(lat);
        check("post_abort_latency", 128'(lat), 128'd10);
        check("post_abort_out", OUTPUT_DATA, C1_CT);

        // Back-to-back: second start presented in the done cycle.
        start_op(C1_KEY, C1_PT);
        wait_done(lat);
        check("b2b_first_latency", 128'(lat), 128'd10);
        check("b2b_first_out", OUTPUT_DATA, C1_CT);
        INPUT_KEY  = B_KEY;
        INPUT_DATA = B_PT;
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b_accept_busy", 128'(busy), 128'd1);
        check("b2b_out_held", OUTPUT_DATA, C1_CT);
        wait_done(lat2);
        check("b2b_done_spacing", 128'(lat2 + 1), 128'd11);
        check("b2b_second_out", OUTPUT_DATA, B_CT);
        check("b2b_rk10", dut.ROUND_KEYS[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        check("busy_done_overlap", 128'(overlap_seen), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
